sw_debouncer: RTL
=================

// Module: sw_debouncer
// PURPOSE
//   Input-side counterpart of the LED output path: conditions the raw board switches/buttons.
//   Synchronises each bit, debounces it with a per-bit stability counter and emits a clean level.
//   Emits one-cycle rise/fall event pulses that feed the rate counter and LED shift register.
//   Sits between board pins and the control logic in the top level.
// PARAMETERS
//   NB_SW          4        number of switch bits conditioned (one independent channel each)
//   NB_DEBOUNCE    20       stability-counter width; must satisfy 2**NB_DEBOUNCE > DEBOUNCE_TICKS-1
//   DEBOUNCE_TICKS 1000000  consecutive cycles a new level must persist before acceptance (>=1)
// PORTS
//   clock      in   1      system clock, all logic on rising edge
//   i_reset    in   1      synchronous reset, active-low
//   i_sw       in   NB_SW  raw asynchronous switch/button pins
//   o_sw       out  NB_SW  debounced stable level per bit
//   o_rise     out  NB_SW  one-cycle pulse when o_sw[k] goes 0->1
//   o_fall     out  NB_SW  one-cycle pulse when o_sw[k] goes 1->0
//   o_valid    out  1      one-cycle pulse: OR of all o_rise|o_fall bits in that cycle
// BEHAVIOUR
//   - Reset (i_reset==0 at a clock edge): sync FFs, counters, o_sw, o_rise, o_fall, o_valid all 0.
//   - Sync: each bit passes a 2-FF synchroniser (sync1 -> sync2); no logic reads sync1.
//   - Per bit k, registered state: stable[k] (drives o_sw[k]) and cnt[k] (NB_DEBOUNCE bits).
//     * sync2==stable: cnt <= 0 (any bounce back restarts the count).
//     * sync2!=stable, cnt < DEBOUNCE_TICKS-1: cnt <= cnt+1.
//     * sync2!=stable, cnt == DEBOUNCE_TICKS-1: stable <= sync2; cnt <= 0;
//       o_rise[k] or o_fall[k] asserted on the same edge that updates o_sw[k].
//   - cnt never exceeds DEBOUNCE_TICKS-1; no wrap-around possible.
//   - Pulses are registered and high for exactly one cycle; held inputs do not retrigger.
//   - Latency: pin change held steady -> o_sw changes DEBOUNCE_TICKS+2 cycles later (2 sync + count).
//   - Glitch rejection: any excursion shorter than DEBOUNCE_TICKS cycles at sync2 leaves o_sw unchanged.
//   - DEBOUNCE_TICKS==1: accepted on the first cycle of disagreement (latency 3).
//   - Bits independent; simultaneous changes on several bits give simultaneous pulses, one o_valid.
//   - o_rise[k] and o_fall[k] are never both high.
//   - Reset mid-count: count is discarded, o_sw returns to 0.
//     * Inputs still high after release: rising pulse DEBOUNCE_TICKS+2 cycles after release.
// STRUCTURE
//   - Shared include (debounce_defs.vh): default DEBOUNCE_TICKS for 100 MHz (10 ms) and sync depth 2.
//   - One sub-module, debounce_bit: synchroniser + counter + stable + edge regs for one bit.
//     * Same parameters (less NB_SW); instantiated NB_SW times via generate.
//   - Top of this block only concatenates outputs and ORs the o_valid reduction.
// TESTING (bench uses DEBOUNCE_TICKS=8, NB_DEBOUNCE=4, NB_SW=4)
//   1 Reset: i_reset=0 with i_sw=4'hF for 5 cycles -> o_sw=0, o_rise=o_fall=0, o_valid=0 throughout.
//   2 Clean press: i_sw 0->4'h1 held -> o_sw=4'h1 and o_rise=4'h1, o_valid=1 exactly 10 cycles later,
//     one cycle only.
//   3 Bounce: i_sw[0] toggles 1,0,1,0 every 3 cycles, then held 1 -> no pulse during bounce;
//     o_rise[0] 10 cycles after last edge.
//   4 Release: from o_sw=4'h1, i_sw=0 held -> o_fall=4'h1 after 10 cycles; o_rise stays 0.
//   5 Simultaneous: i_sw 0->4'hA together -> o_rise=4'hA in one cycle, o_valid single pulse.
//   6 Mid-reset: i_sw=4'h4 held, reset pulsed at cycle 6 of count -> no pulse before reset;
//     o_rise=4'h4 10 cycles after release.

Source files
------------

// File: rtl/sw_debouncer_pkg.sv
// Shared defaults for the switch conditioning path: 10 ms debounce at 100 MHz
// and the synchroniser depth used by every channel.
package sw_debouncer_pkg;

    localparam int DEFAULT_NB_SW          = 4;
    localparam int DEFAULT_NB_DEBOUNCE    = 20;
    localparam int DEFAULT_DEBOUNCE_TICKS = 1_000_000;
    localparam int SYNC_DEPTH             = 2;

endpackage : sw_debouncer_pkg

// File: rtl/sw_debouncer_if.sv
// Pin-side and event-side signals of the switch debouncer.
// The debouncer takes the master view; the consuming control logic takes the slave view.
interface sw_debouncer_if #(
    parameter int NB_SW = 4
);

    logic [NB_SW-1:0] i_sw;
    logic [NB_SW-1:0] o_sw;
    logic [NB_SW-1:0] o_rise;
    logic [NB_SW-1:0] o_fall;
    logic             o_valid;

    modport master (input i_sw, output o_sw, o_rise, o_fall, o_valid);
    modport slave  (output i_sw, input o_sw, o_rise, o_fall, o_valid);

endinterface : sw_debouncer_if

// File: rtl/sw_debouncer_debounce_bit.sv
// One switch channel: synchroniser, stability counter, accepted level and
// registered one-cycle rise/fall pulses.
module debounce_bit
    import sw_debouncer_pkg::*;
#(
    parameter int NB_DEBOUNCE    = DEFAULT_NB_DEBOUNCE,
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [NB_DEBOUNCE-1:0] LAST_TICK = NB_DEBOUNCE'(DEBOUNCE_TICKS - 1);

    logic [SYNC_DEPTH-1:0]  sync;
    logic                   sync_out;
    logic [NB_DEBOUNCE-1:0] cnt;

    assign sync_out = sync[SYNC_DEPTH-1];

    // NOTE: state updates use non-blocking assignments so every register in this
    // block samples the pre-edge values; reset is synchronous, so it lives in the same block.
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            sync   <= '0;
            cnt    <= '0;
            o_sw   <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_DEPTH-2:0], i_sw};
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (sync_out == o_sw) begin
                cnt <= '0;
            end else if (cnt == LAST_TICK) begin
                // New level persisted long enough: accept it and flag the edge together.
                o_sw   <= sync_out;
                cnt    <= '0;
                o_rise <= sync_out;
                o_fall <= ~sync_out;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : debounce_bit

// File: rtl/sw_debouncer.sv
// Conditions the raw board switches: one independent debounce channel per bit,
// plus a single event strobe whenever any channel changes level.
module sw_debouncer
    import sw_debouncer_pkg::*;
#(
    parameter int NB_SW          = DEFAULT_NB_SW,
    parameter int NB_DEBOUNCE    = DEFAULT_NB_DEBOUNCE,
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
    input  logic           clock,
    input  logic           i_reset,
    sw_debouncer_if.master bus
);

    logic [NB_SW-1:0] sw_level;
    logic [NB_SW-1:0] sw_rise;
    logic [NB_SW-1:0] sw_fall;

    for (genvar k = 0; k < NB_SW; k++) begin : g_bit
        debounce_bit #(
            .NB_DEBOUNCE   (NB_DEBOUNCE),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_bit (
            .clock (clock),
            .i_reset(i_reset),
            .i_sw  (bus.i_sw[k]),
            .o_sw  (sw_level[k]),
            .o_rise(sw_rise[k]),
            .o_fall(sw_fall[k])
        );
    end

    assign bus.o_sw    = sw_level;
    assign bus.o_rise  = sw_rise;
    assign bus.o_fall  = sw_fall;
    // Pulses are already registered, so the strobe stays a clean one-cycle pulse.
    assign bus.o_valid = |(sw_rise | sw_fall);

endmodule : sw_debouncer
